// File: rtl/elevator_pkg.sv
// rtl/elevator_pkg.sv - shared constants, state encoding and width helper for the panel debouncer
package elevator_pkg;

  localparam int unsigned BOARD_CLK_HZ          = 50_000_000;
  // 20 us settle window and 1 ms long-press at the 50 MHz board clock
  localparam int unsigned DEFAULT_STABLE_CYCLES = BOARD_CLK_HZ / 50_000;
  localparam int unsigned DEFAULT_HOLD_CYCLES   = BOARD_CLK_HZ / 1_000;

  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_CHANGING = 1'b1
  } state_e;

  function automatic int unsigned cnt_width(input int unsigned max_count);
    return (max_count <= 2) ? 1 : $clog2(max_count);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// rtl/debounce_channel.sv - one button: 2-FF synchroniser, stability FSM, edge pulses and hold pulse
module debounce_channel
  import elevator_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_in,
  output logic btn_level,
  output logic btn_rise,
  output logic btn_fall,
  output logic btn_hold
);

  localparam int unsigned SW = cnt_width(STABLE_CYCLES);
  localparam int unsigned HW = cnt_width(HOLD_CYCLES);
  localparam logic [SW-1:0] STAB_LAST = SW'(STABLE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  state_e        r_state;
  logic [SW-1:0] r_stab_cnt;
  logic          r_level;
  logic          r_rise;
  logic          r_fall;
  logic [HW-1:0] r_hold_cnt;
  logic          r_hold_done;
  logic          r_hold;

  state_e        w_state_nxt;
  logic [SW-1:0] w_cnt_nxt;
  logic          w_level_nxt;
  logic          w_rise_nxt;
  logic          w_fall_nxt;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = '0;
    w_level_nxt = r_level;
    w_rise_nxt  = 1'b0;
    w_fall_nxt  = 1'b0;
    case (r_state)
      ST_STABLE: begin
        if (r_s2 != r_level) begin
          w_state_nxt = ST_CHANGING;
          w_cnt_nxt   = SW'(1);
        end
      end
      ST_CHANGING: begin
        if (r_s2 == r_level) begin
          w_state_nxt = ST_STABLE;
        end else if (r_stab_cnt == STAB_LAST) begin
          w_state_nxt = ST_STABLE;
          w_level_nxt = r_s2;
          w_rise_nxt  = r_s2;
          w_fall_nxt  = ~r_s2;
        end else begin
          w_state_nxt = ST_CHANGING;
          w_cnt_nxt   = r_stab_cnt + 1'b1;
        end
      end
      default: w_state_nxt = ST_STABLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1       <= INIT_LEVEL;
      r_s2       <= INIT_LEVEL;
      r_state    <= ST_STABLE;
      r_stab_cnt <= '0;
      r_level    <= INIT_LEVEL;
      r_rise     <= 1'b0;
      r_fall     <= 1'b0;
    end else begin
      r_s1       <= btn_in;
      r_s2       <= r_s1;
      r_state    <= w_state_nxt;
      r_stab_cnt <= w_cnt_nxt;
      r_level    <= w_level_nxt;
      r_rise     <= w_rise_nxt;
      r_fall     <= w_fall_nxt;
    end
  end

  // Starting "already held" when the level resets high keeps a hold from firing without a fresh rise
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hold_cnt  <= '0;
      r_hold_done <= INIT_LEVEL;
      r_hold      <= 1'b0;
    end else if (!r_level) begin
      r_hold_cnt  <= '0;
      r_hold_done <= 1'b0;
      r_hold      <= 1'b0;
    end else begin
      r_hold <= 1'b0;
      if (!r_hold_done) begin
        if (r_hold_cnt == HOLD_LAST) begin
          r_hold_done <= 1'b1;
          r_hold      <= ~w_fall_nxt;
        end else begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
        end
      end
    end
  end

  assign btn_level = r_level;
  assign btn_rise  = r_rise;
  assign btn_fall  = r_fall;
  assign btn_hold  = r_hold;

endmodule

// File: rtl/multi_button_debouncer.sv
// rtl/multi_button_debouncer.sv - N independent elevator panel button debouncers
module multi_button_debouncer
  import elevator_pkg::*;
#(
  parameter int unsigned N_CH          = 8,
  parameter int unsigned STABLE_CYCLES = DEFAULT_STABLE_CYCLES,
  parameter int unsigned HOLD_CYCLES   = DEFAULT_HOLD_CYCLES,
  parameter logic        INIT_LEVEL    = 1'b0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn_in,
  output logic [N_CH-1:0] btn_level,
  output logic [N_CH-1:0] btn_rise,
  output logic [N_CH-1:0] btn_fall,
  output logic [N_CH-1:0] btn_hold
);

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_channel #(
      .STABLE_CYCLES (STABLE_CYCLES),
      .HOLD_CYCLES   (HOLD_CYCLES),
      .INIT_LEVEL    (INIT_LEVEL)
    ) u_ch (
      .clk       (clk),
      .rst       (rst),
      .btn_in    (btn_in[g]),
      .btn_level (btn_level[g]),
      .btn_rise  (btn_rise[g]),
      .btn_fall  (btn_fall[g]),
      .btn_hold  (btn_hold[g])
    );
  end

endmodule

// File: tb/tb_multi_button_debouncer.sv
// tb/tb_multi_button_debouncer.sv - directed self-checking bench for multi_button_debouncer
module tb_multi_button_debouncer;

  logic       clk;
  logic       rst;
  logic [3:0] btn_in;
  logic [3:0] btn_level;
  logic [3:0] btn_rise;
  logic [3:0] btn_fall;
  logic [3:0] btn_hold;

  int tests;
  int fails;

  multi_button_debouncer #(
    .N_CH          (4),
    .STABLE_CYCLES (4),
    .HOLD_CYCLES   (10),
    .INIT_LEVEL    (1'b0)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .btn_in    (btn_in),
    .btn_level (btn_level),
    .btn_rise  (btn_rise),
    .btn_fall  (btn_fall),
    .btn_hold  (btn_hold)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] pat;
    logic       any_rise;
    logic       any_lvl;
    tests  = 0;
    fails  = 0;
    rst    = 1'b1;
    btn_in = 4'b0000;
    step(); step(); step();
    check("rst_level", btn_level, 4'b0000);
    check("rst_rise",  btn_rise,  4'b0000);
    check("rst_fall",  btn_fall,  4'b0000);
    check("rst_hold",  btn_hold,  4'b0000);
    rst = 1'b0;
    step(); step();

    // clean press on ch0, accepted on the 6th edge
    btn_in = 4'b0001;
    for (int e = 1; e <= 7; e++) begin
      step();
      check("t1_level", btn_level, (e >= 6) ? 4'b0001 : 4'b0000);
      check("t1_rise",  btn_rise,  (e == 6) ? 4'b0001 : 4'b0000);
    end
    // release ch0 well before the hold would fire
    btn_in = 4'b0000;
    for (int e = 1; e <= 8; e++) begin
      step();
      check("t4_level", btn_level, (e >= 6) ? 4'b0000 : 4'b0001);
      check("t4_fall",  btn_fall,  (e == 6) ? 4'b0001 : 4'b0000);
      check("t4_rise",  btn_rise,  4'b0000);
      check("t4_hold",  btn_hold,  4'b0000);
    end

    // bounce on ch1: count restarts after the glitch, rise on edge 10
    pat = 8'b1111_0111;
    for (int e = 1; e <= 11; e++) begin
      btn_in[1] = (e <= 8) ? pat[e-1] : 1'b1;
      step();
      check("t2_level", btn_level, (e >= 10) ? 4'b0010 : 4'b0000);
      check("t2_rise",  btn_rise,  (e == 10) ? 4'b0010 : 4'b0000);
    end
    btn_in[1] = 1'b0;
    repeat (8) step();
    check("t2_rel_level", btn_level, 4'b0000);

    // a 3-cycle pulse alone on ch3 is rejected
    any_rise = 1'b0;
    any_lvl  = 1'b0;
    for (int e = 1; e <= 12; e++) begin
      btn_in[3] = (e <= 3);
      step();
      any_rise = any_rise | btn_rise[3];
      any_lvl  = any_lvl | btn_level[3];
    end
    check("t2_glitch", {2'b00, any_lvl, any_rise}, 4'b0000);

    // hold on ch2: exactly one pulse 10 cycles after rise
    btn_in = 4'b0100;
    for (int c = 1; c <= 30; c++) begin
      step();
      check("t3_rise", btn_rise, (c == 6)  ? 4'b0100 : 4'b0000);
      check("t3_hold", btn_hold, (c == 16) ? 4'b0100 : 4'b0000);
    end
    btn_in = 4'b0000;
    repeat (8) step();
    check("t3_rel_level", btn_level, 4'b0000);
    btn_in = 4'b0100;
    for (int c = 1; c <= 20; c++) begin
      step();
      check("t3b_rise", btn_rise, (c == 6)  ? 4'b0100 : 4'b0000);
      check("t3b_hold", btn_hold, (c == 16) ? 4'b0100 : 4'b0000);
    end
    btn_in = 4'b0000;
    repeat (8) step();

    // release lands on the hold terminal edge: fall wins
    btn_in = 4'b0100;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c == 10) btn_in = 4'b0000;
      check("t3c_fall", btn_fall, (c == 16) ? 4'b0100 : 4'b0000);
      check("t3c_hold", btn_hold, 4'b0000);
    end

    // all channels together
    btn_in = 4'b1111;
    for (int e = 1; e <= 7; e++) begin
      step();
      check("t5_level", btn_level, (e >= 6) ? 4'b1111 : 4'b0000);
      check("t5_rise",  btn_rise,  (e == 6) ? 4'b1111 : 4'b0000);
    end
    btn_in = 4'b0000;
    for (int e = 1; e <= 7; e++) begin
      step();
      check("t5_fall",  btn_fall,  (e == 6) ? 4'b1111 : 4'b0000);
      check("t5_hold",  btn_hold,  4'b0000);
    end
    repeat (2) step();

    // reset in the middle of a press discards progress
    btn_in = 4'b0001;
    repeat (4) step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t5r_level", btn_level, 4'b0000);
    check("t5r_rise",  btn_rise,  4'b0000);
    for (int e = 1; e <= 7; e++) begin
      step();
      check("t5r_post_level", btn_level, (e >= 6) ? 4'b0001 : 4'b0000);
      check("t5r_post_rise",  btn_rise,  (e == 6) ? 4'b0001 : 4'b0000);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
